user_id_readback: RTL and testbench

Parametrised user-project identification block that holds an ID_WORDS × 32-bit identifier fixed at integration time. The identifier is captured into internal registers after reset, then served two ways: over a single-cycle request/acknowledge parallel read port, and as a serial bitstream for pad or scan-out. It sits beside the housekeeping logic in the management area. Word 0 is exported continuously as the legacy 32-bit mask_rev.

---
 rtl/user_id_readback.sv | 175 +++++++++++++++++
 tb/tb_user_id_readback.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/user_id_readback.sv
// Integration-time user project identifier: loaded word-by-word after reset, then
// served through a request/acknowledge parallel port and an MSB-first serial stream.
module user_id_readback #(
  parameter int                     ID_WORDS        = 2,
  parameter logic [ID_WORDS*32-1:0] USER_PROJECT_ID = '0,
  parameter int                     CLK_DIV         = 4,
  localparam int                    AW              = $clog2(ID_WORDS > 2 ? ID_WORDS : 2)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  output logic [31:0]   rd_data,
  output logic          rd_err,
  input  logic          ser_start,
  output logic          ser_busy,
  output logic          ser_done,
  output logic          ser_out,
  output logic          id_valid,
  output logic [31:0]   mask_rev
);

  localparam int TOTAL = ID_WORDS * 32;
  localparam int BW    = $clog2(TOTAL);
  localparam int DW    = $clog2(CLK_DIV > 2 ? CLK_DIV : 2);

  typedef enum logic {ST_LOAD, ST_READY} state_t;
  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   load_idx_q, load_idx_d;
  logic            id_valid_q, id_valid_d;
  logic [TOTAL-1:0] id_flat;

  logic            rd_ack_q, rd_ack_d;
  logic            rd_err_q, rd_err_d;
  logic [31:0]     rd_data_q, rd_data_d;
  logic [31:0]     word_sel;
  logic            in_range;

  ser_state_t      ser_state_q, ser_state_d;
  logic [BW-1:0]   bit_idx_q, bit_idx_d;
  logic [DW-1:0]   div_q, div_d;
  logic            ser_out_q, ser_out_d;
  logic            ser_done_q, ser_done_d;

  genvar gi;
  generate
    for (gi = 0; gi < ID_WORDS; gi++) begin : g_word
      logic [31:0] word_q, word_d;

      always_comb begin
        word_d = word_q;
        if (state_q == ST_LOAD && load_idx_q == AW'(gi)) begin
          word_d = USER_PROJECT_ID[32*gi +: 32];
        end
      end

      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) word_q <= '0;
        else          word_q <= word_d;
      end

      assign id_flat[32*gi +: 32] = word_q;
    end
  endgenerate

  // Load sequencer: one word per cycle, LOAD is only re-entered through reset.
  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    id_valid_d = id_valid_q;
    if (state_q == ST_LOAD) begin
      if (load_idx_q == AW'(ID_WORDS - 1)) begin
        state_d    = ST_READY;
        id_valid_d = 1'b1;
      end else begin
        load_idx_d = load_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    in_range = int'(rd_addr) < ID_WORDS;
    word_sel = '0;
    for (int i = 0; i < ID_WORDS; i++) begin
      if (int'(rd_addr) == i) word_sel = id_flat[32*i +: 32];
    end
  end

  // The !rd_ack_q term forces at least one idle cycle between acknowledged reads.
  always_comb begin
    rd_ack_d  = 1'b0;
    rd_err_d  = 1'b0;
    rd_data_d = rd_data_q;
    if (rd_req && id_valid_q && !rd_ack_q) begin
      rd_ack_d  = 1'b1;
      rd_err_d  = !in_range;
      rd_data_d = in_range ? word_sel : 32'd0;
    end
  end

  always_comb begin
    ser_state_d = ser_state_q;
    bit_idx_d   = bit_idx_q;
    div_d       = div_q;
    ser_out_d   = ser_out_q;
    ser_done_d  = 1'b0;
    case (ser_state_q)
      SER_IDLE: begin
        if (ser_start && id_valid_q) begin
          ser_state_d = SER_SHIFT;
          bit_idx_d   = BW'(TOTAL - 1);
          div_d       = '0;
          ser_out_d   = id_flat[TOTAL-1];
        end
      end
      SER_SHIFT: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d = '0;
          if (bit_idx_q == '0) begin
            ser_state_d = SER_IDLE;
            ser_out_d   = 1'b0;
            ser_done_d  = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q - 1'b1;
            ser_out_d = id_flat[bit_idx_d];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: ser_state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_LOAD;
      load_idx_q  <= '0;
      id_valid_q  <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_data_q   <= '0;
      ser_state_q <= SER_IDLE;
      bit_idx_q   <= '0;
      div_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_idx_q  <= load_idx_d;
      id_valid_q  <= id_valid_d;
      rd_ack_q    <= rd_ack_d;
      rd_err_q    <= rd_err_d;
      rd_data_q   <= rd_data_d;
      ser_state_q <= ser_state_d;
      bit_idx_q   <= bit_idx_d;
      div_q       <= div_d;
      ser_out_q   <= ser_out_d;
      ser_done_q  <= ser_done_d;
    end
  end

  assign rd_ack   = rd_ack_q;
  assign rd_err   = rd_err_q;
  assign rd_data  = rd_data_q;
  assign ser_busy = (ser_state_q == SER_SHIFT);
  assign ser_done = ser_done_q;
  assign ser_out  = ser_out_q;
  assign id_valid = id_valid_q;
  assign mask_rev = id_flat[31:0];

endmodule

// File: tb/tb_user_id_readback.sv
// Directed bench for user_id_readback: load timing, parallel reads, serial dump,
// concurrent use and asynchronous reset, across three parameter sets.
module tb_user_id_readback;

  localparam logic [63:0] ID_A = 64'h1234_5678_CAFE_F00D;
  localparam logic [95:0] ID_B = 96'hAAAA_0002_BBBB_0001_CCCC_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // dut_a: 2 words, CLK_DIV=4
  logic        rd_req_a = 0, ser_start_a = 0;
  logic [0:0]  rd_addr_a = '0;
  logic        rd_ack_a, rd_err_a, ser_busy_a, ser_done_a, ser_out_a, id_valid_a;
  logic [31:0] rd_data_a, mask_rev_a;
  // dut_b: 3 words
  logic        rd_req_b = 0, ser_start_b = 0;
  logic [1:0]  rd_addr_b = '0;
  logic        rd_ack_b, rd_err_b, ser_busy_b, ser_done_b, ser_out_b, id_valid_b;
  logic [31:0] rd_data_b, mask_rev_b;
  // dut_c: 2 words, CLK_DIV=1
  logic        rd_req_c = 0, ser_start_c = 0;
  logic [0:0]  rd_addr_c = '0;
  logic        rd_ack_c, rd_err_c, ser_busy_c, ser_done_c, ser_out_c, id_valid_c;
  logic [31:0] rd_data_c, mask_rev_c;

  user_id_readback #(.ID_WORDS(2), .USER_PROJECT_ID(ID_A), .CLK_DIV(4)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .rd_req(rd_req_a), .rd_addr(rd_addr_a),
    .rd_ack(rd_ack_a), .rd_data(rd_data_a), .rd_err(rd_err_a), .ser_start(ser_start_a),
    .ser_busy(ser_busy_a), .ser_done(ser_done_a), .ser_out(ser_out_a),
    .id_valid(id_valid_a), .mask_rev(mask_rev_a));

  user_id_readback #(.ID_WORDS(3), .USER_PROJECT_ID(ID_B), .CLK_DIV(4)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .rd_req(rd_req_b), .rd_addr(rd_addr_b),
    .rd_ack(rd_ack_b), .rd_data(rd_data_b), .rd_err(rd_err_b), .ser_start(ser_start_b),
    .ser_busy(ser_busy_b), .ser_done(ser_done_b), .ser_out(ser_out_b),
    .id_valid(id_valid_b), .mask_rev(mask_rev_b));

  user_id_readback #(.ID_WORDS(2), .USER_PROJECT_ID(ID_A), .CLK_DIV(1)) dut_c (
    .wb_clk_i(clk), .wb_rst_i(rst), .rd_req(rd_req_c), .rd_addr(rd_addr_c),
    .rd_ack(rd_ack_c), .rd_data(rd_data_c), .rd_err(rd_err_c), .ser_start(ser_start_c),
    .ser_busy(ser_busy_c), .ser_done(ser_done_c), .ser_out(ser_out_c),
    .id_valid(id_valid_c), .mask_rev(mask_rev_c));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] stream0, stream3, stream_c;
  int busy_cnt, done_cnt;

  initial begin
    // Reset release with a read already pending on dut_a
    rd_req_a  = 1'b1;
    rd_addr_a = 1'b1;
    repeat (2) tick();
    check_eq("reset_flags_a", {rd_ack_a, rd_err_a, ser_busy_a, ser_done_a, ser_out_a, id_valid_a}, 0);
    check_eq("reset_mask_a", mask_rev_a, 0);
    check_eq("reset_rddata_a", rd_data_a, 0);
    rst = 1'b0;
    tick();  // edge 1
    check_eq("e1_mask_rev", mask_rev_a, 32'hCAFE_F00D);
    check_eq("e1_id_valid", id_valid_a, 0);
    check_eq("e1_no_ack", rd_ack_a, 0);
    tick();  // edge 2
    check_eq("e2_id_valid", id_valid_a, 1);
    check_eq("e2_no_ack", rd_ack_a, 0);
    tick();  // edge 3
    check_eq("rd1_ack", rd_ack_a, 1);
    check_eq("rd1_data", rd_data_a, 32'h1234_5678);
    check_eq("rd1_err", rd_err_a, 0);
    tick();
    check_eq("rd1_ack_clear", rd_ack_a, 0);
    check_eq("rd1_data_held", rd_data_a, 32'h1234_5678);
    tick();
    check_eq("rd2_reack", rd_ack_a, 1);
    rd_req_a = 1'b0;
    tick();

    // Out-of-range and in-range reads on the 3-word instance
    check_eq("b_id_valid", id_valid_b, 1);
    check_eq("b_mask_rev", mask_rev_b, 32'hCCCC_0000);
    rd_addr_b = 2'd3;
    rd_req_b  = 1'b1;
    tick();
    check_eq("b_oor_ack", rd_ack_b, 1);
    check_eq("b_oor_err", rd_err_b, 1);
    check_eq("b_oor_data", rd_data_b, 0);
    rd_req_b = 1'b0;
    tick();
    check_eq("b_oor_err_clear", {rd_ack_b, rd_err_b}, 0);
    rd_addr_b = 2'd2;
    rd_req_b  = 1'b1;
    tick();
    check_eq("b_w2_data", rd_data_b, 32'hAAAA_0002);
    check_eq("b_w2_err", rd_err_b, 0);
    rd_req_b = 1'b0;
    tick();

    // Concurrent read and serial dump with CLK_DIV=1
    rd_addr_c   = 1'b0;
    rd_req_c    = 1'b1;
    ser_start_c = 1'b1;
    tick();  // accepting edge
    rd_req_c    = 1'b0;
    ser_start_c = 1'b0;
    check_eq("c_rd_ack", rd_ack_c, 1);
    check_eq("c_rd_data", rd_data_c, 32'hCAFE_F00D);
    stream_c = '0;
    busy_cnt = 0;
    for (int c = 1; c <= 64; c++) begin
      busy_cnt += int'(ser_busy_c);
      stream_c = {stream_c[62:0], ser_out_c};
      tick();
    end
    check_eq("c_busy_cycles", busy_cnt, 64);
    check_eq("c_stream", stream_c, ID_A);
    check_eq("c_done_cycle65", {ser_done_c, ser_busy_c, ser_out_c}, 3'b100);
    tick();

    // Serial dump with CLK_DIV=4 and an ignored restart request mid-shift
    ser_start_a = 1'b1;
    tick();
    ser_start_a = 1'b0;
    stream0 = '0;
    stream3 = '0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 256; c++) begin
      busy_cnt += int'(ser_busy_a);
      done_cnt += int'(ser_done_a);
      if (c % 4 == 0) stream0 = {stream0[62:0], ser_out_a};
      if (c % 4 == 3) stream3 = {stream3[62:0], ser_out_a};
      ser_start_a = (c == 99);
      tick();
    end
    ser_start_a = 1'b0;
    check_eq("a_busy_cycles", busy_cnt, 256);
    check_eq("a_no_early_done", done_cnt, 0);
    check_eq("a_stream_ph0", stream0, ID_A);
    check_eq("a_stream_ph3", stream3, ID_A);
    check_eq("a_done_pulse", {ser_done_a, ser_busy_a, ser_out_a}, 3'b100);
    tick();
    check_eq("a_after_done", {ser_done_a, ser_busy_a, ser_out_a}, 3'b000);
    tick();

    // Asynchronous reset at cycle 50 of a shift with a read just acknowledged
    ser_start_a = 1'b1;
    tick();
    ser_start_a = 1'b0;
    repeat (49) tick();
    rd_addr_a = 1'b0;
    rd_req_a  = 1'b1;
    tick();
    check_eq("pre_rst_ack", rd_ack_a, 1);
    check_eq("pre_rst_busy", ser_busy_a, 1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_flags", {rd_ack_a, rd_err_a, ser_busy_a, ser_done_a, ser_out_a, id_valid_a}, 0);
    check_eq("async_rst_data", {rd_data_a, mask_rev_a}, 0);
    rd_req_a = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      done_cnt += int'(ser_done_a);
    end
    check_eq("rst_no_done", done_cnt, 0);
    rst = 1'b0;
    tick();
    done_cnt += int'(ser_done_a);
    check_eq("rerun_e1_mask", mask_rev_a, 32'hCAFE_F00D);
    check_eq("rerun_e1_valid", id_valid_a, 0);
    tick();
    done_cnt += int'(ser_done_a);
    check_eq("rerun_e2_valid", id_valid_a, 1);
    check_eq("rerun_no_done", done_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
